// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding and word-offset constant shared by mem_arbiter files
package mem_arb_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DM_WAIT = 3'd1,
    S_IF_WAIT = 3'd2,
    S_DM_DONE = 3'd3,
    S_IF_DONE = 3'd4
  } state_e;
  localparam int OFS = 2;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline fetch/data ports and backing-memory bus of mem_arbiter
interface mem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall;
  modport master (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata, stall
  );
  modport slave (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_arbiter_fetch_buf.sv
// fetch_buf: one-entry word-tagged instruction buffer, present only when FETCH_BUF_EN is defined
module fetch_buf import mem_arb_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [AW-OFS-1:0] load_tag_i,
  input  logic [DW-1:0]     load_data_i,
  input  logic              inval_i,
  input  logic [AW-OFS-1:0] inval_tag_i,
  input  logic [AW-OFS-1:0] look_tag_i,
  output logic              hit_o,
  output logic [DW-1:0]     data_o
);
  logic              valid_q, valid_d;
  logic [AW-OFS-1:0] tag_q, tag_d;
  logic [DW-1:0]     data_q, data_d;
  always_comb begin
    valid_d = load_i ? 1'b1 : (inval_i && inval_tag_i == tag_q) ? 1'b0 : valid_q;
    tag_d   = load_i ? load_tag_i : tag_q;
    data_d  = load_i ? load_data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
  assign hit_o  = valid_q && tag_q == look_tag_i;
  assign data_o = data_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between fetch and data ports; FETCH_BUF_EN adds a fetch buffer
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.master bus
);
  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d, live_q, live_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          dm_any, fb_hit;
  logic [DW-1:0] fb_data;
  assign dm_any = bus.dm_rd | bus.dm_wr;
`ifdef FETCH_BUF_EN
  fetch_buf #(.AW(AW), .DW(DW)) u_fetch_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (state_q == S_IF_WAIT && bus.mem_ack),
    .load_tag_i  (mem_addr_q[AW-1:OFS]),
    .load_data_i (bus.mem_rdata),
    .inval_i     (state_q == S_DM_WAIT && bus.mem_ack && mem_we_q),
    .inval_tag_i (mem_addr_q[AW-1:OFS]),
    .look_tag_i  (bus.if_addr[AW-1:OFS]),
    .hit_o       (fb_hit),
    .data_o      (fb_data)
  );
`else
  assign fb_hit  = 1'b0;
  assign fb_data = '0;
`endif
  // live_q drops for good if the requester withdraws mid-transaction (flush)
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    live_d      = live_q;
    unique case (state_q)
      S_IDLE: begin
        if (dm_any) begin
          state_d     = S_DM_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_wr;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          live_d      = 1'b1;
        end else if (bus.if_req && fb_hit) begin
          state_d    = S_IF_DONE;
          if_rdata_d = fb_data;
          live_d     = 1'b1;
        end else if (bus.if_req) begin
          state_d     = S_IF_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          live_d      = 1'b1;
        end
      end
      S_DM_WAIT: begin
        live_d = live_q & dm_any;
        if (bus.mem_ack) begin
          state_d    = S_DM_DONE;
          mem_req_d  = 1'b0;
          dm_rdata_d = (live_d && !mem_we_q) ? bus.mem_rdata : dm_rdata_q;
        end
      end
      S_IF_WAIT: begin
        live_d = live_q & bus.if_req;
        if (bus.mem_ack) begin
          state_d    = S_IF_DONE;
          mem_req_d  = 1'b0;
          if_rdata_d = live_d ? bus.mem_rdata : if_rdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      live_q      <= live_d;
    end
  end
  assign bus.if_ready  = state_q == S_IF_DONE && live_q;
  assign bus.dm_ready  = state_q == S_DM_DONE && live_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall     = (bus.if_req & ~bus.if_ready) | (dm_any & ~bus.dm_ready);
endmodule
